// File: rtl/divclk_monitor_if.sv
// divclk_monitor_if: divided-clock input plus the monitor's strobes, measurement and status
interface divclk_monitor_if;
  logic        div_clk_in;
  logic        rise_pulse;
  logic        fall_pulse;
  logic [31:0] half_period;
  logic        period_valid;
  logic        locked;
  logic        fault;
  modport master (
    output div_clk_in,
    input  rise_pulse, fall_pulse, half_period, period_valid, locked, fault
  );
  modport slave (
    input  div_clk_in,
    output rise_pulse, fall_pulse, half_period, period_valid, locked, fault
  );
endinterface

// File: rtl/divclk_monitor.sv
// divclk_monitor: samples a divided clock, strobes its edges, measures half-periods and tracks lock
module divclk_monitor #(
  parameter int unsigned N_EXP       = 5000,
  parameter int unsigned TOL         = 4,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  divclk_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;
  localparam logic [31:0] LO  = N_EXP > TOL ? 32'(N_EXP - TOL) : 32'd0;
  localparam logic [31:0] HI  = 32'(N_EXP + TOL);
  localparam logic [31:0] TMO = 32'(2 * N_EXP);
  localparam int GW = $clog2(LOCK_CNT + 1);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] s_q, s_d;
  logic [31:0] hcnt_q, hcnt_d, half_period_q, half_period_d, meas;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic prev_q, prev_d, s_last, edge_ev, armed, match;
  logic rise_pulse_q, rise_pulse_d, fall_pulse_q, fall_pulse_d;
  logic period_valid_q, period_valid_d, locked_q, locked_d, fault_q, fault_d;
  always_comb begin
    s_d = SYNC_STAGES'({s_q, bus.div_clk_in});
    s_last = s_q[SYNC_STAGES-1];
    prev_d = s_last;
    edge_ev = s_last ^ prev_q;
    meas = &hcnt_q ? hcnt_q : hcnt_q + 32'd1;
    hcnt_d = edge_ev ? '0 : meas;
    match = meas >= LO && meas <= HI;
    armed = state_q == ACQUIRE || state_q == LOCKED;
    good_inc = good_q + GW'(1);
    rise_pulse_d = s_last & ~prev_q;
    fall_pulse_d = ~s_last & prev_q;
    period_valid_d = edge_ev & armed;
    half_period_d = period_valid_d ? meas : half_period_q;
    locked_d = state_q == LOCKED;
    fault_d = fault_q | (state_q == LOST);
    state_d = state_q;
    good_d = good_q;
    // an edge always wins over a same-cycle timeout; its long measurement mismatches anyway
    if (edge_ev && !armed) begin
      state_d = ACQUIRE;
      good_d = '0;
    end else if (edge_ev && !match) begin
      state_d = state_q == LOCKED ? LOST : ACQUIRE;
      good_d = '0;
    end else if (edge_ev && state_q == ACQUIRE) begin
      good_d = good_inc;
      state_d = good_inc == GW'(LOCK_CNT) ? LOCKED : ACQUIRE;
    end else if (!edge_ev && armed && hcnt_q == TMO) begin
      state_d = LOST;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q <= '0;
      prev_q <= 1'b0;
      hcnt_q <= '0;
      good_q <= '0;
      half_period_q <= '0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      period_valid_q <= 1'b0;
      locked_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      prev_q <= prev_d;
      hcnt_q <= hcnt_d;
      good_q <= good_d;
      half_period_q <= half_period_d;
      rise_pulse_q <= rise_pulse_d;
      fall_pulse_q <= fall_pulse_d;
      period_valid_q <= period_valid_d;
      locked_q <= locked_d;
      fault_q <= fault_d;
    end
  end
  assign bus.rise_pulse = rise_pulse_q;
  assign bus.fall_pulse = fall_pulse_q;
  assign bus.half_period = half_period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked = locked_q;
  assign bus.fault = fault_q;
endmodule

// File: tb/tb_divclk_monitor.sv
// tb_divclk_monitor: directed plus random half-periods checked every cycle against an event-level model
module tb_divclk_monitor;
  localparam int N = 5, TOL = 1, LC = 3, SS = 2, D = SS + 1;
  typedef enum {M_IDLE, M_ACQ, M_LOCK, M_LOST} mstate_t;
  typedef struct {int t; logic lv;} tog_t;
  logic clk = 1'b0, rst = 1'b1;
  int tests = 0, fails = 0;
  int cyc = 0, last_ev = 0, good = 0, rises = 0, falls = 0, pvs = 0;
  logic cur = 1'b0;
  tog_t q[$];
  mstate_t ms = M_IDLE;
  logic e_rise = 0, e_fall = 0, e_pv = 0, e_locked = 0, e_fault = 0;
  logic [31:0] e_half = '0;
  divclk_monitor_if bus();
  divclk_monitor #(.N_EXP(N), .TOL(TOL), .LOCK_CNT(LC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask
  // a level change seen by the first sync flop at posedge t+1 shows up as a strobe after posedge t+D
  task automatic model(input logic r);
    bit ev, armed;
    logic lv;
    int meas;
    tog_t e;
    cyc++;
    if (r) begin
      q.delete();
      ms = M_IDLE; good = 0; e_rise = 0; e_fall = 0; e_pv = 0; e_locked = 0; e_fault = 0; e_half = '0;
      if (cur) begin e.t = cyc; e.lv = 1'b1; q.push_back(e); end
      return;
    end
    ev = q.size() > 0 && q[0].t + D == cyc;
    lv = ev ? q[0].lv : 1'b0;
    if (ev) void'(q.pop_front());
    e_locked = ms == M_LOCK;
    e_fault = e_fault | (ms == M_LOST);
    e_rise = ev && lv;
    e_fall = ev && !lv;
    armed = ms == M_ACQ || ms == M_LOCK;
    meas = cyc - last_ev;
    e_pv = ev && armed;
    if (e_pv) e_half = 32'(meas);
    if (ev) begin
      if (!armed) begin ms = M_ACQ; good = 0; end
      else if (meas < N - TOL || meas > N + TOL) begin ms = ms == M_LOCK ? M_LOST : M_ACQ; good = 0; end
      else if (ms == M_ACQ) begin good++; if (good == LC) ms = M_LOCK; end
      last_ev = cyc;
    end else if (armed && meas > 2 * N) ms = M_LOST;
  endtask
  task automatic tick(input logic r, input logic lv);
    tog_t e;
    if (lv !== cur) begin
      if (q.size() > 0 && q[$].t == cyc) void'(q.pop_back());
      else begin e.t = cyc; e.lv = lv; q.push_back(e); end
      cur = lv;
    end
    rst = r;
    bus.div_clk_in = lv;
    @(posedge clk);
    model(r);
    @(negedge clk);
    rises += int'(bus.rise_pulse);
    falls += int'(bus.fall_pulse);
    pvs += int'(bus.period_valid);
    chk("rise_pulse", bus.rise_pulse, e_rise);
    chk("fall_pulse", bus.fall_pulse, e_fall);
    chk("period_valid", bus.period_valid, e_pv);
    chk("half_period", bus.half_period, e_half);
    chk("locked", bus.locked, e_locked);
    chk("fault", bus.fault, e_fault);
  endtask
  task automatic half(input int n);
    tick(1'b0, ~cur);
    repeat (n - 1) tick(1'b0, cur);
  endtask
  initial begin
    bus.div_clk_in = 1'b0;
    tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("s1_locked", bus.locked, 1'b0);
    chk("s1_fault", bus.fault, 1'b0);
    chk("s1_half", bus.half_period, 32'd0);
    repeat (6) half(5);
    chk("s2_locked", bus.locked, 1'b1);
    chk("s2_half", bus.half_period, 32'd5);
    repeat (3) half(6);
    chk("s3_locked_tol", bus.locked, 1'b1);
    chk("s3_half_tol", bus.half_period, 32'd6);
    half(8); half(5);
    chk("s3_locked_drop", bus.locked, 1'b0);
    chk("s3_fault", bus.fault, 1'b1);
    chk("s3_half_bad", bus.half_period, 32'd8);
    repeat (5) half(5);
    chk("s4_relock", bus.locked, 1'b1);
    repeat (14) tick(1'b0, cur);
    chk("s4_timeout_locked", bus.locked, 1'b0);
    chk("s4_timeout_fault", bus.fault, 1'b1);
    repeat (6) half(5);
    chk("s4_relock2", bus.locked, 1'b1);
    chk("s4_fault_sticky", bus.fault, 1'b1);
    tick(1'b1, 1'b0);
    chk("s5_rst_locked", bus.locked, 1'b0);
    chk("s5_rst_fault", bus.fault, 1'b0);
    pvs = 0; rises = 0;
    half(5);
    chk("s5_arm_no_pv", 32'(pvs), 32'd0);
    chk("s5_arm_rise", 32'(rises), 32'd1);
    repeat (3) half(5);
    tick(1'b1, 1'b0);
    repeat (2) half(5);
    rises = 0; falls = 0;
    tick(1'b0, 1'b1); tick(1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b0);
    chk("s6_glitch_rise", 32'(rises), 32'd1);
    chk("s6_glitch_fall", 32'(falls), 32'd1);
    chk("s6_glitch_half", bus.half_period, 32'd1);
    repeat (2) half(5);
    chk("s6_good_reset", bus.locked, 1'b0);
    half(5);
    chk("s6_lock_after", bus.locked, 1'b1);
    repeat (60) half(int'($urandom_range(12, 3)));
    repeat (25) tick(1'b0, cur);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
